// File: rtl/fetch_stage.sv
// LEGv8 IF stage: owns the PC, addresses the instruction ROM and registers the fetched
// word into IF/ID. Handles stall, flush and branch redirect, and halts on a bad fetch PC.
module fetch_stage #(
  parameter int N = 64,
  parameter int IW = 32,
  parameter int AW = 6,
  parameter logic [IW-1:0] NOP_WORD = 32'hd503201f
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          branch_taken,
  input  logic [N-1:0]  branch_target,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_q,
  output logic [N-1:0]  if_id_pc,
  output logic [IW-1:0] if_id_instr,
  output logic          if_id_valid,
  output logic          fetch_fault,
  output logic          state_dbg
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t       state;
  logic [N-1:0] pc;
  logic         pc_bad;

  // Misaligned, or at/above the first byte past the ROM (no wrap back to 0).
  assign pc_bad    = (pc[1:0] != 2'b00) || (pc[N-1:AW+2] != '0);
  assign imem_addr = pc[AW+1:2];
  assign state_dbg = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_WORD;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else if (state == RUN) begin
      if (branch_taken) begin
        // The target is only checked once it has become the PC.
        pc          <= branch_target;
        if_id_instr <= NOP_WORD;
        if_id_valid <= 1'b0;
      end else if (pc_bad) begin
        state       <= HALT;
        fetch_fault <= 1'b1;
        if_id_instr <= NOP_WORD;
        if_id_valid <= 1'b0;
      end else if (flush) begin
        pc          <= pc + N'(4);
        if_id_instr <= NOP_WORD;
        if_id_valid <= 1'b0;
      end else if (!stall) begin
        pc          <= pc + N'(4);
        if_id_pc    <= pc;
        if_id_instr <= imem_q;
        if_id_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized self-checking bench for fetch_stage against a byte-address reference model.
module tb_fetch_stage;

  localparam int N = 64;
  localparam int IW = 32;
  localparam int AW = 6;
  localparam logic [IW-1:0] NOP = 32'hd503201f;
  localparam int W = N + IW + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          stall = 1'b0, flush = 1'b0, branch_taken = 1'b0;
  logic [N-1:0]  branch_target = '0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_q;
  logic [N-1:0]  if_id_pc;
  logic [IW-1:0] if_id_instr;
  logic          if_id_valid, fetch_fault, state_dbg;

  logic [IW-1:0] rom [0:(1<<AW)-1];
  assign imem_q = rom[imem_addr];

  fetch_stage #(.N(N), .IW(IW), .AW(AW), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_q(imem_q), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  longint unsigned m_pc, m_ipc;
  logic [IW-1:0]   m_instr;
  bit              m_valid, m_fault, m_halt;

  function automatic void model_reset();
    m_pc = 0; m_ipc = 0; m_instr = NOP; m_valid = 0; m_fault = 0; m_halt = 0;
  endfunction

  function automatic void model_edge(bit st, bit fl, bit bt, longint unsigned tgt);
    bit bad;
    bad = (m_pc % 4 != 0) || (m_pc >= 4 * (1 << AW));
    if (m_halt) return;
    if (bt) begin
      m_pc = tgt; m_valid = 0; m_instr = NOP;
    end else if (bad) begin
      m_fault = 1; m_halt = 1; m_valid = 0; m_instr = NOP;
    end else if (fl) begin
      m_pc = m_pc + 4; m_valid = 0; m_instr = NOP;
    end else if (!st) begin
      m_ipc = m_pc; m_instr = rom[m_pc / 4]; m_valid = 1; m_pc = m_pc + 4;
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [W-1:0] e;
    exp_q.push_back({m_ipc, m_instr, m_valid, m_fault});
    e = exp_q.pop_front();
    check({tag, ".pc"},    if_id_pc,                 e[W-1 -: N]);
    check({tag, ".instr"}, N'(if_id_instr),          N'(e[IW+1:2]));
    check({tag, ".valid"}, N'(if_id_valid),          N'(e[1]));
    check({tag, ".fault"}, N'(fetch_fault),          N'(e[0]));
    check({tag, ".addr"},  N'(imem_addr),            N'((m_pc / 4) % (1 << AW)));
    check({tag, ".halt"},  N'(state_dbg),            N'(m_halt));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit st, input bit fl, input bit bt, input logic [N-1:0] tgt,
                      input string tag);
    stall = st; flush = fl; branch_taken = bt; branch_target = tgt;
    model_edge(st, fl, bt, tgt);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rom[0] = 32'hf8000000; rom[1] = 32'hf8008001; rom[2] = 32'hf8010002;
    rom[15] = 32'hb400004e;
    model_reset();
    #12;
    compare_all("reset");
    @(negedge clk);
    reset = 1'b1;

    step(0, 0, 0, 0, "edge1");
    check("edge1_instr", N'(if_id_instr), N'(32'hf8000000));
    step(0, 0, 0, 0, "edge2");
    check("edge2_pc", if_id_pc, 64'h4);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, "stall");
    step(0, 0, 0, 0, "resume");
    check("resume_instr", N'(if_id_instr), N'(32'hf8010002));
    step(1, 0, 1, 64'h3c, "br_stall");
    step(0, 0, 0, 0, "br_land");
    check("br_land_instr", N'(if_id_instr), N'(32'hb400004e));
    step(0, 1, 0, 0, "flush");
    step(0, 0, 0, 0, "post_flush");
    check("post_flush_pc", if_id_pc, 64'h44);

    // Random traffic, kept inside the ROM by redirecting before the end.
    for (int i = 0; i < 300; i++) begin
      bit st, fl, bt;
      logic [N-1:0] tgt;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      bt = ($urandom_range(0, 9) == 0) || (m_pc >= 64'hf0);
      tgt = N'($urandom_range(0, (1 << AW) - 8)) * 4;
      step(st, fl, bt, tgt, "rand");
    end

    step(0, 0, 1, 64'h42, "br_bad");
    step(0, 0, 0, 0, "fault");
    check("fault_set", N'(fetch_fault), 64'h1);
    for (int i = 0; i < 6; i++)
      step(i[0], i[1], i[2], 64'h10, "halt_hold");
    async_reset("halt_reset1");

    for (int i = 0; i < 64; i++) step(0, 0, 0, 0, "freerun");
    check("last_pc", if_id_pc, 64'hfc);
    step(0, 0, 0, 0, "rom_end");
    check("rom_end_fault", N'(fetch_fault), 64'h1);
    step(1, 1, 1, 64'h0, "halt_hold2");
    async_reset("halt_reset2");
    step(0, 0, 0, 0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
